// File: rtl/frame_writer_dualbuf_seq_pkg.sv
// frame_writer_dualbuf_seq_pkg: shared frame geometry, pixel width and state encoding
package frame_writer_dualbuf_seq_pkg;
  localparam int FB_WIDTH = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_DEPTH = FB_WIDTH * FB_HEIGHT;
  localparam int FB_AW = 17;
  localparam int RGB_W = 12;
  typedef enum logic [1:0] {IDLE, FILL, SWAP_REQ, SWAP_WAIT} state_t;
endpackage

// File: rtl/frame_writer_dualbuf_seq_if.sv
// frame_writer_dualbuf_seq_if: raster pixel stream with start-of-frame marker
interface frame_writer_dualbuf_seq_if;
  logic s_valid_sys;
  logic s_ready_sys;
  logic s_sof_sys;
  logic [frame_writer_dualbuf_seq_pkg::RGB_W-1:0] s_data_sys;
  modport master(output s_valid_sys, s_sof_sys, s_data_sys, input s_ready_sys);
  modport slave(input s_valid_sys, s_sof_sys, s_data_sys, output s_ready_sys);
endinterface

// File: rtl/frame_writer_dualbuf_seq_swap.sv
// swap_handshake_ctl: holds the swap request, waits for the bank flip and retries on timeout
module swap_handshake_ctl
  import frame_writer_dualbuf_seq_pkg::*;
#(
  parameter int REQ_HOLD = 8,
  parameter int RETRY_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        active_buf,
  output logic        req,
  output logic        done,
  output logic        retry,
  output logic [15:0] frames_done
);
  localparam int CW = $clog2(RETRY_CYCLES + REQ_HOLD);
  state_t st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic buf_at_req;
  // state, shared hold/retry counter, bank seen at request time, completed-swap count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      buf_at_req <= 1'b0;
      frames_done <= '0;
    end else begin
      st <= st_nx;
      cnt <= cnt_nx;
      if (st == IDLE && start) buf_at_req <= active_buf;
      if (done) frames_done <= frames_done + 16'd1;
    end
  // a flip seen in either swap phase wins over hold expiry and retry
  always_comb begin
    st_nx = st;
    cnt_nx = cnt;
    req = st == SWAP_REQ;
    done = (st == SWAP_REQ || st == SWAP_WAIT) && active_buf != buf_at_req;
    retry = 1'b0;
    if (st == IDLE) st_nx = start ? SWAP_REQ : IDLE;
    else if (done) begin
      st_nx = IDLE;
      cnt_nx = '0;
    end else if (st == SWAP_REQ) begin
      st_nx = cnt == CW'(REQ_HOLD - 1) ? SWAP_WAIT : SWAP_REQ;
      cnt_nx = cnt == CW'(REQ_HOLD - 1) ? '0 : cnt + CW'(1);
    end else begin
      retry = cnt == CW'(RETRY_CYCLES - 1);
      st_nx = retry ? SWAP_REQ : SWAP_WAIT;
      cnt_nx = retry ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/frame_writer_dualbuf_seq.sv
// frame_writer_dualbuf_seq: writes a pixel stream into the inactive bank and requests a swap per frame
module frame_writer_dualbuf_seq
  import frame_writer_dualbuf_seq_pkg::*;
#(
  parameter int WIDTH = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int AW = FB_AW,
  parameter int REQ_HOLD = 8,
  parameter int RETRY_CYCLES = 2000000
) (
  input  logic                    clk_sys,
  input  logic                    rst_n_sys,
  input  logic                    enable_sys,
  frame_writer_dualbuf_seq_if.slave s,
  input  logic                    active_buf_sys,
  output logic                    wr_en_sys,
  output logic [AW-1:0]           wr_addr_sys,
  output logic [RGB_W-1:0]        wr_data_sys,
  output logic                    swap_req_sys,
  output logic                    busy_sys,
  output logic [15:0]             frames_done_sys,
  output logic                    sof_err_sys,
  output logic                    swap_retry_sys
);
  localparam logic [AW-1:0] LAST = AW'(WIDTH * HEIGHT - 1);
  state_t st, st_nx;
  logic [AW-1:0] addr, addr_nx;
  logic acc, we, start, done;
  // stream FSM: the swap phases are sequenced by the handshake block, so this FSM parks in SWAP_REQ until done
  always_comb begin
    s.s_ready_sys = st == IDLE ? enable_sys : st == FILL;
    acc = s.s_valid_sys && s.s_ready_sys;
    we = acc && (st == FILL || s.s_sof_sys);
    start = we && st == FILL && !s.s_sof_sys && addr == LAST;
    st_nx = st;
    addr_nx = addr;
    if (we) begin
      addr_nx = s.s_sof_sys ? AW'(1) : start ? '0 : addr + AW'(1);
      st_nx = start ? SWAP_REQ : FILL;
    end else if (st == SWAP_REQ && done) st_nx = IDLE;
  end
  // state, address counter and the registered write port
  always_ff @(posedge clk_sys or negedge rst_n_sys)
    if (!rst_n_sys) begin
      st <= IDLE;
      addr <= '0;
      wr_en_sys <= 1'b0;
      wr_addr_sys <= '0;
      wr_data_sys <= '0;
      sof_err_sys <= 1'b0;
    end else begin
      st <= st_nx;
      addr <= addr_nx;
      wr_en_sys <= we;
      sof_err_sys <= we && st == FILL && s.s_sof_sys;
      if (we) begin
        wr_addr_sys <= s.s_sof_sys ? '0 : addr;
        wr_data_sys <= s.s_data_sys;
      end
    end
  assign busy_sys = st != IDLE;
  swap_handshake_ctl #(.REQ_HOLD(REQ_HOLD), .RETRY_CYCLES(RETRY_CYCLES)) u_swap (
    .clk(clk_sys),
    .rst_n(rst_n_sys),
    .start(start),
    .active_buf(active_buf_sys),
    .req(swap_req_sys),
    .done(done),
    .retry(swap_retry_sys),
    .frames_done(frames_done_sys)
  );
endmodule
